sdram_page_arbiter: RTL and testbench
=====================================

# sdram_page_arbiter

Multi-channel SDRAM page-transfer negotiator, parametrised successor to the single-write/single-read negotiator in the XEM3010 memory interface. Arbitrates up to `NUM_CH` FIFO channels, each independently configured as write (FIFO→SDRAM) or read (SDRAM→FIFO). It issues one-page `cmd_pagewrite` or `cmd_pageread` commands to `sdramctrl` and keeps an independent wrapping row pointer per channel. Sits between the per-channel clock-crossing FIFOs and `sdramctrl`. All logic is on the rising edge of `sdram_clk`; the caller supplies the inverted clock if required.

## Interface
- `NUM_CH`, 4: number of channels, 1..8
- `ROW_W`, 15: row address width
- `LVL_W`, 12: FIFO level width, in words
- `FIFO_DEPTH`, 2048: read-channel FIFO capacity, in words
- `PAGE_WORDS`, 512: words per page transfer
- `CH_W`, `$clog2(NUM_CH)` (min 1): channel index width

- `sdram_clk` in 1: sole clock
- `async_rst_n` in 1: asynchronous, active-low reset
- `ch_en` in NUM_CH: channel enable
- `ch_dir` in NUM_CH: 1 = write channel, 0 = read channel
- `ch_level` in NUM_CH*LVL_W: FIFO occupancy as seen on the SDRAM side; channel i uses bits [i*LVL_W +: LVL_W]
- `ch_base_row` in NUM_CH*ROW_W: first row of each channel's region
- `ch_num_rows` in NUM_CH*ROW_W: region size in rows; 0 = full 2^ROW_W range
- `ch_restart` in NUM_CH: 1-cycle pulse that reloads the channel's pointer to its base (e.g. frame_done)
- `cmd_pagewrite` out 1: page write request to the controller
- `cmd_pageread` out 1: page read request to the controller
- `rowaddr` out ROW_W: row address for the current command
- `cmd_ack` in 1: controller accepted the command
- `cmd_done` in 1: controller finished the page
- `grant_ch` out CH_W: index of the channel owning the current transfer, used to steer the FIFO data muxes
- `grant_valid` out 1: high from REQ through BUSY
- `ch_page_done` out NUM_CH: 1-cycle completion pulse per channel

## Operation
- Ready condition for channel i: `ch_en[i]` high, and
  - write channel: level ≥ PAGE_WORDS
  - read channel: FIFO_DEPTH − level ≥ PAGE_WORDS
- State machine:
  - IDLE: if any channel is ready, choose by round-robin, starting at `last_grant+1` mod NUM_CH; latch `grant_ch`, direction and `rowaddr = ptr[grant_ch]`; go to REQ. Otherwise stay in IDLE.
  - REQ: assert `cmd_pagewrite` or `cmd_pageread` per the latched direction. On `cmd_ack`: increment the granted channel's pointer, go to BUSY.
  - BUSY: on `cmd_done`, pulse `ch_page_done[grant_ch]`, set `last_grant = grant_ch`, go to IDLE.
- Pointer update: `next = ptr + 1`. If `ch_num_rows != 0` and `next == base + num_rows` (ROW_W-bit arithmetic), then `next = base`. With `num_rows == 0` the pointer wraps modulo 2^ROW_W.
- `ch_restart[i]` sets `ptr[i] = base[i]`. If it coincides with the ack increment on the same channel, restart wins. A restart during REQ/BUSY does not change the latched `rowaddr`.
- Mode and enable changes are sampled only in IDLE. Dropping `ch_en` mid-transfer does not abort the transfer.
- `cmd_done` is ignored in IDLE and REQ. `cmd_ack` is ignored outside REQ.

## Timing
- Reset values: state IDLE; `cmd_pagewrite`, `cmd_pageread`, `grant_valid`, `ch_page_done` = 0; `grant_ch` = 0; `rowaddr` = 0; `last_grant` = NUM_CH−1, so channel 0 has first priority.
- Pointers reload from `ch_base_row` on the first clock after reset deassertion.
- All outputs are registered.
- Cycle N: IDLE sees a ready channel. Cycle N+1: cmd, `rowaddr`, `grant_ch` and `grant_valid` are valid.
- `cmd_*` stays high through the cycle in which `cmd_ack` is sampled and drops the following cycle.
- `rowaddr` and `grant_ch` are stable from REQ until the return to IDLE.
- `ch_page_done` is high in the cycle after `cmd_done` is sampled; `grant_valid` falls in the same cycle.
- At least one IDLE cycle separates consecutive commands.
- `async_rst_n` low at any point forces reset values immediately. An in-flight controller command is abandoned; the controller is reset by the same signal.

## Test plan
- Ch0 write, level 600 → `cmd_pagewrite` 1 cycle later with `rowaddr` = base (0x0100); ack → ptr 0x0101; done → `ch_page_done` = 4'b0001.
- Ch0 and ch2 ready continuously, ack/done after 3 cycles each → grants alternate 0, 2, 0, 2; ch1 (disabled) and ch3 (level 100) are never granted.
- Ch1 base 0x7FFE, num_rows 3 → successive rowaddr 0x7FFE, 0x7FFF, 0x0000, 0x7FFE.
- Read channel, FIFO_DEPTH 2048: level 1537 → no request; level 1536 → `cmd_pageread`.
- `ch_restart` in the same cycle as `cmd_ack` → ptr = base, and latched `rowaddr` is unchanged until done.
- `async_rst_n` pulsed low during BUSY → all outputs 0 within the same cycle; after release the next grant goes to ch0 with `rowaddr` = base.

Source files
------------

// File: rtl/sdram_page_arbiter.sv
// Round-robin page-transfer arbiter between per-channel FIFOs and sdramctrl.
// Each channel owns a wrapping row pointer inside its own SDRAM region.
module sdram_page_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ROW_W      = 15,
  parameter int LVL_W      = 12,
  parameter int FIFO_DEPTH = 2048,
  parameter int PAGE_WORDS = 512,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    sdram_clk,
  input  logic                    async_rst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       ch_dir,
  input  logic [NUM_CH*LVL_W-1:0] ch_level,
  input  logic [NUM_CH*ROW_W-1:0] ch_base_row,
  input  logic [NUM_CH*ROW_W-1:0] ch_num_rows,
  input  logic [NUM_CH-1:0]       ch_restart,
  output logic                    cmd_pagewrite,
  output logic                    cmd_pageread,
  output logic [ROW_W-1:0]        rowaddr,
  input  logic                    cmd_ack,
  input  logic                    cmd_done,
  output logic [CH_W-1:0]         grant_ch,
  output logic                    grant_valid,
  output logic [NUM_CH-1:0]       ch_page_done,
  output logic [1:0]              fsm_state
);

  // Handshake: cmd_pagewrite/cmd_pageread act as valid and cmd_ack as ready;
  // the command is transferred in the cycle both are high, after which the
  // request drops and the arbiter holds the grant until cmd_done.

  localparam int PAD_CH = 1 << CH_W;
  localparam int RD_MAX = FIFO_DEPTH - PAGE_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   last_grant;
  logic              init_done;
  logic [ROW_W-1:0]  ptr      [NUM_CH];
  logic [ROW_W-1:0]  ptr_next [NUM_CH];
  logic [ROW_W-1:0]  base     [NUM_CH];
  logic [ROW_W-1:0]  num_rows [NUM_CH];
  logic [ROW_W-1:0]  limit    [NUM_CH];
  logic [NUM_CH-1:0] ready;
  logic [PAD_CH-1:0] ready_pad;
  logic [PAD_CH-1:0] dir_pad;
  logic              any_ready;
  logic [CH_W-1:0]   sel;
  logic [CH_W-1:0]   cand;
  int                cand_i;

  assign fsm_state = state;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      base[i]     = ch_base_row[i*ROW_W +: ROW_W];
      num_rows[i] = ch_num_rows[i*ROW_W +: ROW_W];
      limit[i]    = base[i] + num_rows[i];
      ptr_next[i] = ptr[i] + 1'b1;
      // A zero row count means the region spans the whole row space.
      if ((num_rows[i] != '0) && (ptr_next[i] == limit[i]))
        ptr_next[i] = base[i];
    end
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_dir[i])
        ready[i] = ch_en[i] && (int'(ch_level[i*LVL_W +: LVL_W]) >= PAGE_WORDS);
      else
        ready[i] = ch_en[i] && (RD_MAX >= 0) &&
                   (int'(ch_level[i*LVL_W +: LVL_W]) <= RD_MAX);
    end
  end

  always_comb begin
    ready_pad = '0;
    dir_pad   = '0;
    ready_pad[NUM_CH-1:0] = ready;
    dir_pad[NUM_CH-1:0]   = ch_dir;
  end

  // Scan from the farthest candidate down so the channel right after
  // last_grant is the one left selected.
  always_comb begin
    any_ready = 1'b0;
    sel       = '0;
    cand_i    = 0;
    cand      = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand_i = (int'(last_grant) + k) % NUM_CH;
      cand   = CH_W'(cand_i);
      if (ready_pad[cand]) begin
        any_ready = 1'b1;
        sel       = cand;
      end
    end
  end

  always_ff @(posedge sdram_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state         <= ST_IDLE;
      cmd_pagewrite <= 1'b0;
      cmd_pageread  <= 1'b0;
      grant_valid   <= 1'b0;
      ch_page_done  <= '0;
      grant_ch      <= '0;
      rowaddr       <= '0;
      last_grant    <= CH_W'(NUM_CH - 1);
      init_done     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) ptr[i] <= '0;
    end else begin
      init_done    <= 1'b1;
      ch_page_done <= '0;

      // Restart has priority over the post-ack increment.
      for (int i = 0; i < NUM_CH; i++) begin
        if (!init_done || ch_restart[i])
          ptr[i] <= base[i];
        else if ((state == ST_REQ) && cmd_ack && (grant_ch == CH_W'(i)))
          ptr[i] <= ptr_next[i];
      end

      case (state)
        ST_IDLE: begin
          if (any_ready) begin
            grant_ch      <= sel;
            grant_valid   <= 1'b1;
            cmd_pagewrite <= dir_pad[sel];
            cmd_pageread  <= ~dir_pad[sel];
            rowaddr       <= init_done ? ptr[sel] : base[sel];
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (cmd_ack) begin
            cmd_pagewrite <= 1'b0;
            cmd_pageread  <= 1'b0;
            state         <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cmd_done) begin
            for (int i = 0; i < NUM_CH; i++)
              if (grant_ch == CH_W'(i)) ch_page_done[i] <= 1'b1;
            last_grant  <= grant_ch;
            grant_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_page_arbiter.sv
// Directed bench for sdram_page_arbiter: a transaction-level reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_sdram_page_arbiter;

  localparam int NCH = 4;
  localparam int RW  = 15;
  localparam int LW  = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NCH-1:0]  ch_en = '0;
  logic [NCH-1:0]  ch_dir = '0;
  logic [NCH*LW-1:0] ch_level = '0;
  logic [NCH*RW-1:0] ch_base_row = '0;
  logic [NCH*RW-1:0] ch_num_rows = '0;
  logic [NCH-1:0]  ch_restart = '0;
  logic            cmd_ack = 1'b0;
  logic            cmd_done = 1'b0;
  logic            cmd_pagewrite, cmd_pageread, grant_valid;
  logic [RW-1:0]   rowaddr;
  logic [1:0]      grant_ch;
  logic [NCH-1:0]  ch_page_done;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  sdram_page_arbiter dut (
    .sdram_clk(clk), .async_rst_n(rst_n), .ch_en(ch_en), .ch_dir(ch_dir),
    .ch_level(ch_level), .ch_base_row(ch_base_row), .ch_num_rows(ch_num_rows),
    .ch_restart(ch_restart), .cmd_pagewrite(cmd_pagewrite),
    .cmd_pageread(cmd_pageread), .rowaddr(rowaddr), .cmd_ack(cmd_ack),
    .cmd_done(cmd_done), .grant_ch(grant_ch), .grant_valid(grant_valid),
    .ch_page_done(ch_page_done), .fsm_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    cmd_ack = 1'b0; cmd_done = 1'b0; ch_restart = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ch(input int i, input bit en, input bit dir, input int lvl,
                        input int base, input int num);
    ch_en[i]  = en;
    ch_dir[i] = dir;
    ch_level[i*LW +: LW]    = LW'(lvl);
    ch_base_row[i*RW +: RW] = RW'(base);
    ch_num_rows[i*RW +: RW] = RW'(num);
  endtask

  // ---------------- reference model ----------------
  // Transaction view: each page goes pick -> accepted -> finished.
  logic [RW-1:0] m_ptr [NCH];
  int  m_phase = 0;   // 0 waiting for a ready channel, 1 awaiting ack, 2 awaiting done
  int  m_last  = NCH - 1;
  int  m_ch    = 0;
  bit  m_init  = 0;
  logic          e_wr = 0, e_rd = 0, e_gv = 0;
  logic [1:0]    e_gch = 0;
  logic [RW-1:0] e_row = 0;
  logic [NCH-1:0] e_done = 0;

  function automatic int lvl_of(input int i);
    return int'(ch_level[i*LW +: LW]);
  endfunction
  function automatic logic [RW-1:0] base_of(input int i);
    return ch_base_row[i*RW +: RW];
  endfunction
  function automatic int rows_of(input int i);
    return int'(ch_num_rows[i*RW +: RW]);
  endfunction
  function automatic bit model_ready(input int i);
    if (!ch_en[i]) return 0;
    if (ch_dir[i]) return lvl_of(i) >= 512;
    return (2048 - lvl_of(i)) >= 512;
  endfunction
  // Advance inside the region by offset arithmetic modulo the region size.
  function automatic logic [RW-1:0] advance(input int i, input logic [RW-1:0] p);
    int off, size;
    size = (rows_of(i) == 0) ? (1 << RW) : rows_of(i);
    off  = (int'(p) - int'(base_of(i)) + (1 << RW)) % (1 << RW);
    off  = (off + 1) % size;
    return RW'((int'(base_of(i)) + off) % (1 << RW));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_last = NCH - 1; m_ch = 0; m_init = 0;
      e_wr = 0; e_rd = 0; e_gv = 0; e_gch = 0; e_row = 0; e_done = 0;
      for (int i = 0; i < NCH; i++) m_ptr[i] = '0;
    end else begin
      e_done = '0;
      if (m_phase == 0) begin
        for (int k = 1; k <= NCH; k++) begin
          int c;
          c = (m_last + k) % NCH;
          if (model_ready(c)) begin
            m_ch = c; e_gch = 2'(c); e_gv = 1;
            e_row = m_init ? m_ptr[c] : base_of(c);
            e_wr = ch_dir[c]; e_rd = !ch_dir[c];
            m_phase = 1;
            break;
          end
        end
      end else if (m_phase == 1) begin
        if (cmd_ack) begin
          m_ptr[m_ch] = advance(m_ch, m_ptr[m_ch]);
          e_wr = 0; e_rd = 0; m_phase = 2;
        end
      end else if (cmd_done) begin
        e_done[m_ch] = 1'b1; e_gv = 0; m_last = m_ch; m_phase = 0;
      end
      for (int i = 0; i < NCH; i++)
        if (!m_init || ch_restart[i]) m_ptr[i] = base_of(i);
      m_init = 1;
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_pagewrite", 32'(cmd_pagewrite), 32'(e_wr));
      check("cyc_pageread",  32'(cmd_pageread),  32'(e_rd));
      check("cyc_grant_valid", 32'(grant_valid), 32'(e_gv));
      check("cyc_page_done", 32'(ch_page_done), 32'(e_done));
      if (e_gv) begin
        check("cyc_grant_ch", 32'(grant_ch), 32'(e_gch));
        check("cyc_rowaddr",  32'(rowaddr),  32'(e_row));
      end
    end
  end

  // ---------------- controller driver tasks ----------------
  task automatic wait_cmd(output bit ok);
    ok = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (cmd_pagewrite || cmd_pageread) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL cmd_timeout actual=no_cmd expected=cmd t=%0t", $time);
    end
  endtask

  task automatic do_page(input int ack_dly, input int done_dly,
                         output int g_ch, output logic [RW-1:0] g_row, output logic g_wr);
    bit ok;
    wait_cmd(ok);
    g_ch = ok ? int'(grant_ch) : -1;
    g_row = rowaddr;
    g_wr = cmd_pagewrite;
    if (!ok) return;
    repeat (ack_dly) @(posedge clk);
    #1 cmd_ack = 1'b1;
    @(posedge clk); #1 cmd_ack = 1'b0;
    repeat (done_dly) @(posedge clk);
    #1 cmd_done = 1'b1;
    @(posedge clk); #1 cmd_done = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  int g; logic [RW-1:0] r; logic w; bit ok;
  int exp_ch [4] = '{0, 2, 0, 2};
  int exp_rw [4] = '{'h0100, 'h0200, 'h0101, 'h0201};
  int wrap_rw [4] = '{'h7FFE, 'h7FFF, 'h0000, 'h7FFE};

  initial begin
    #1;
    #3;
    check("rst_pagewrite", 32'(cmd_pagewrite), 0);
    check("rst_grant_valid", 32'(grant_valid), 0);
    check("rst_rowaddr", 32'(rowaddr), 0);

    // Single write page on ch0, with a stray done during REQ.
    set_ch(0, 1, 1, 0, 'h0100, 0);
    do_reset();
    @(posedge clk); #1 ch_level[0 +: LW] = LW'(600);
    @(posedge clk); @(negedge clk);
    check("t1_pagewrite", 32'(cmd_pagewrite), 1);
    check("t1_rowaddr", 32'(rowaddr), 'h0100);
    check("t1_grant", 32'({grant_valid, grant_ch}), 32'h4);
    #1 cmd_done = 1'b1;
    @(posedge clk); #1 cmd_done = 1'b0;
    check("t1_done_ignored", 32'(cmd_pagewrite), 1);
    cmd_ack = 1'b1;
    @(posedge clk); #1 cmd_ack = 1'b0;
    check("t1_cmd_drop", 32'({cmd_pagewrite, grant_valid}), 32'b01);
    cmd_done = 1'b1;
    @(posedge clk); #1 cmd_done = 1'b0;
    check("t1_page_done", 32'(ch_page_done), 32'b0001);
    check("t1_gv_fall", 32'(grant_valid), 0);
    do_page(1, 2, g, r, w);
    ch_level[0 +: LW] = '0;
    check("t1_second_row", 32'(r), 'h0101);

    // Round robin between ch0 and ch2; ch1 disabled, ch3 under a page.
    set_ch(0, 1, 1, 600, 'h0100, 0);
    set_ch(1, 0, 1, 600, 'h7FFE, 3);
    set_ch(2, 1, 0, 0,   'h0200, 0);
    set_ch(3, 1, 1, 100, 'h0300, 0);
    do_reset();
    for (int p = 0; p < 4; p++) begin
      do_page(3, 3, g, r, w);
      check("t2_grant", 32'(g), 32'(exp_ch[p]));
      check("t2_row", 32'(r), 32'(exp_rw[p]));
    end

    // Small region straddling the top of the row space on ch1.
    ch_en = '0;
    set_ch(1, 1, 1, 600, 'h7FFE, 3);
    do_reset();
    for (int p = 0; p < 4; p++) begin
      do_page(0, 1, g, r, w);
      check("t3_grant", 32'(g), 1);
      check("t3_wrap_row", 32'(r), 32'(wrap_rw[p]));
    end

    // Read-channel free-space threshold on ch3.
    ch_en = '0;
    set_ch(3, 1, 0, 1537, 'h0300, 0);
    do_reset();
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("t4_no_req", 32'({cmd_pageread, cmd_pagewrite, grant_valid}), 0);
    end
    ch_level[3*LW +: LW] = LW'(1536);
    do_page(0, 1, g, r, w);
    check("t4_grant", 32'(g), 3);
    check("t4_is_read", 32'(w), 0);
    check("t4_row", 32'(r), 'h0300);

    // Restart coinciding with ack on ch0.
    ch_en = '0;
    set_ch(0, 1, 1, 600, 'h0100, 0);
    do_reset();
    do_page(0, 1, g, r, w);
    check("t5_first_row", 32'(r), 'h0100);
    wait_cmd(ok);
    check("t5_second_row", 32'(rowaddr), 'h0101);
    #1 cmd_ack = 1'b1; ch_restart = 4'b0001;
    @(posedge clk); #1 cmd_ack = 1'b0; ch_restart = '0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t5_row_held", 32'(rowaddr), 'h0101);
    end
    #1 cmd_done = 1'b1;
    @(posedge clk); #1 cmd_done = 1'b0;
    do_page(0, 1, g, r, w);
    check("t5_after_restart", 32'(r), 'h0100);

    // Asynchronous reset in the middle of a transfer.
    wait_cmd(ok);
    #1 cmd_ack = 1'b1;
    @(posedge clk); #1 cmd_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_cmd", 32'({cmd_pagewrite, cmd_pageread}), 0);
    check("t6_rst_gv", 32'(grant_valid), 0);
    check("t6_rst_done", 32'(ch_page_done), 0);
    check("t6_rst_gch", 32'(grant_ch), 0);
    check("t6_rst_row", 32'(rowaddr), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_page(0, 1, g, r, w);
    check("t6_grant", 32'(g), 0);
    check("t6_row", 32'(r), 'h0100);

    ch_en = '0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
